// File: rtl/mac_pkg.sv
// Shared types and parameter sanity helpers for the multiply-accumulate stage.
package mac_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } mac_state_t;

  // The product must fit the accumulator and at least one product makes a result.
  function automatic bit params_ok(input int width, input int acc_width, input int len);
    return (acc_width >= 2 * width) && (len >= 1);
  endfunction

endpackage

// File: rtl/sat_adder.sv
// Unsigned adder that clamps to all ones when the true sum does not fit.
module sat_adder #(
  parameter int AccWidth = 24
) (
  input  logic [AccWidth-1:0] a,
  input  logic [AccWidth-1:0] b,
  output logic [AccWidth-1:0] sum,
  output logic                ovf
);

  logic [AccWidth:0] full;

  // One extra bit of headroom exposes the carry that signals saturation.
  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    ovf  = full[AccWidth];
    if (full[AccWidth]) begin
      sum = {AccWidth{1'b1}};
    end else begin
      sum = full[AccWidth-1:0];
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Sums Len consecutive unsigned products into a saturating accumulator and
// hands each completed sum downstream over a valid/ready handshake.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter  int Width    = 8,
  parameter  int AccWidth = 24,
  parameter  int Len      = 4,
  localparam int CntWidth = $clog2(Len + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [2*Width-1:0]    prod_i,
  input  logic                  prod_valid_i,
  output logic                  prod_ready_o,
  input  logic                  clear_i,
  output logic [AccWidth-1:0]   acc_o,
  output logic                  acc_valid_o,
  input  logic                  acc_ready_i,
  output logic                  ovf_o,
  output logic [CntWidth-1:0]   cnt_o
);

  if (!params_ok(Width, AccWidth, Len)) begin : g_param_check
    $error("mac_accumulator: requires AccWidth >= 2*Width and Len >= 1");
  end

  mac_state_t            state;
  logic [AccWidth-1:0]   prod_ext;
  logic [AccWidth-1:0]   next_sum;
  logic                  add_ovf;
  logic                  prod_fire;
  logic                  result_fire;
  logic                  last_prod;

  assign prod_ext    = AccWidth'(prod_i);
  assign prod_fire   = prod_valid_i & prod_ready_o;
  assign result_fire = acc_valid_o & acc_ready_i;
  assign last_prod   = (cnt_o == CntWidth'(Len - 1));

  sat_adder #(
    .AccWidth(AccWidth)
  ) u_sat_adder (
    .a   (acc_o),
    .b   (prod_ext),
    .sum (next_sum),
    .ovf (add_ovf)
  );

  // Control FSM; every output is a register updated here. Clear beats both
  // handshakes, so a product arriving with clear is swallowed without effect.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= INIT;
      prod_ready_o <= 1'b0;
      acc_o        <= {AccWidth{1'b0}};
      acc_valid_o  <= 1'b0;
      ovf_o        <= 1'b0;
      cnt_o        <= {CntWidth{1'b0}};
    end else begin
      case (state)
        INIT: begin
          state        <= ACC;
          prod_ready_o <= 1'b1;
        end
        ACC: begin
          if (clear_i) begin
            acc_o <= {AccWidth{1'b0}};
            ovf_o <= 1'b0;
            cnt_o <= {CntWidth{1'b0}};
          end else if (prod_fire) begin
            acc_o <= next_sum;
            ovf_o <= ovf_o | add_ovf;
            if (last_prod) begin
              state        <= HOLD;
              cnt_o        <= CntWidth'(Len);
              acc_valid_o  <= 1'b1;
              prod_ready_o <= 1'b0;
            end else begin
              cnt_o <= cnt_o + {{(CntWidth-1){1'b0}}, 1'b1};
            end
          end else begin
            acc_o <= acc_o;
          end
        end
        HOLD: begin
          // No same-cycle bypass: restart takes one edge, leaving one bubble.
          if (clear_i || result_fire) begin
            state        <= ACC;
            acc_o        <= {AccWidth{1'b0}};
            ovf_o        <= 1'b0;
            cnt_o        <= {CntWidth{1'b0}};
            acc_valid_o  <= 1'b0;
            prod_ready_o <= 1'b1;
          end else begin
            state <= HOLD;
          end
        end
        default: begin
          state        <= INIT;
          prod_ready_o <= 1'b0;
          acc_o        <= {AccWidth{1'b0}};
          acc_valid_o  <= 1'b0;
          ovf_o        <= 1'b0;
          cnt_o        <= {CntWidth{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: a 24-bit instance for the main
// scenarios and a 17-bit instance to exercise saturation.
module tb_mac_accumulator;

  logic        clk;
  logic        rst;
  logic [15:0] prod;
  logic        prod_valid;
  logic        prod_ready;
  logic        clear;
  logic [23:0] acc;
  logic        acc_valid;
  logic        acc_ready;
  logic        ovf;
  logic [2:0]  cnt;

  logic [15:0] s_prod;
  logic        s_prod_valid;
  logic        s_prod_ready;
  logic        s_clear;
  logic [16:0] s_acc;
  logic        s_acc_valid;
  logic        s_acc_ready;
  logic        s_ovf;
  logic [2:0]  s_cnt;

  int checks = 0;
  int fails  = 0;

  mac_accumulator #(.Width(8), .AccWidth(24), .Len(4)) dut (
    .clk_i(clk), .rst_i(rst), .prod_i(prod), .prod_valid_i(prod_valid),
    .prod_ready_o(prod_ready), .clear_i(clear), .acc_o(acc),
    .acc_valid_o(acc_valid), .acc_ready_i(acc_ready), .ovf_o(ovf), .cnt_o(cnt)
  );

  mac_accumulator #(.Width(8), .AccWidth(17), .Len(4)) dut_sat (
    .clk_i(clk), .rst_i(rst), .prod_i(s_prod), .prod_valid_i(s_prod_valid),
    .prod_ready_o(s_prod_ready), .clear_i(s_clear), .acc_o(s_acc),
    .acc_valid_o(s_acc_valid), .acc_ready_i(s_acc_ready), .ovf_o(s_ovf), .cnt_o(s_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] p);
    prod       = p;
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (prod_ready !== 1'b0) begin fails++; $display("FAIL reset_prod_ready got %0d want 0", prod_ready); end
    checks++; if (acc !== 24'd0) begin fails++; $display("FAIL reset_acc got %0d want 0", acc); end
    checks++; if (acc_valid !== 1'b0) begin fails++; $display("FAIL reset_acc_valid got %0d want 0", acc_valid); end
    checks++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %0d want 0", ovf); end
    checks++; if (cnt !== 3'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    rst = 1'b0;
    #1;
    checks++; if (prod_ready !== 1'b0) begin fails++; $display("FAIL release_prod_ready got %0d want 0", prod_ready); end
    tick();
    checks++; if (prod_ready !== 1'b1) begin fails++; $display("FAIL first_prod_ready got %0d want 1", prod_ready); end
  endtask

  task automatic test_basic_sum();
    acc_ready = 1'b1;
    prod = 16'd10; prod_valid = 1'b1; tick();
    prod = 16'd20; tick();
    checks++; if (acc !== 24'd30) begin fails++; $display("FAIL basic_running_acc got %0d want 30", acc); end
    checks++; if (cnt !== 3'd2) begin fails++; $display("FAIL basic_running_cnt got %0d want 2", cnt); end
    prod = 16'd30; tick();
    prod = 16'd40; tick();
    prod_valid = 1'b0;
    checks++; if (acc_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %0d want 1", acc_valid); end
    checks++; if (acc !== 24'd100) begin fails++; $display("FAIL basic_acc got %0d want 100", acc); end
    checks++; if (ovf !== 1'b0) begin fails++; $display("FAIL basic_ovf got %0d want 0", ovf); end
    checks++; if (cnt !== 3'd4) begin fails++; $display("FAIL basic_cnt got %0d want 4", cnt); end
    checks++; if (prod_ready !== 1'b0) begin fails++; $display("FAIL basic_bubble got %0d want 0", prod_ready); end
    tick();
    checks++; if (acc_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_drop got %0d want 0", acc_valid); end
    checks++; if (prod_ready !== 1'b1) begin fails++; $display("FAIL basic_ready_back got %0d want 1", prod_ready); end
    checks++; if (acc !== 24'd0) begin fails++; $display("FAIL basic_acc_restart got %0d want 0", acc); end
    checks++; if (cnt !== 3'd0) begin fails++; $display("FAIL basic_cnt_restart got %0d want 0", cnt); end
  endtask

  task automatic test_saturation();
    s_acc_ready  = 1'b1;
    s_prod       = 16'd65025;
    s_prod_valid = 1'b1;
    repeat (2) tick();
    checks++; if (s_acc !== 17'd130050) begin fails++; $display("FAIL sat_two got %0d want 130050", s_acc); end
    checks++; if (s_ovf !== 1'b0) begin fails++; $display("FAIL sat_two_ovf got %0d want 0", s_ovf); end
    tick();
    checks++; if (s_acc !== 17'd131071) begin fails++; $display("FAIL sat_three got %0d want 131071", s_acc); end
    checks++; if (s_ovf !== 1'b1) begin fails++; $display("FAIL sat_three_ovf got %0d want 1", s_ovf); end
    tick();
    s_prod_valid = 1'b0;
    checks++; if (s_acc_valid !== 1'b1) begin fails++; $display("FAIL sat_valid got %0d want 1", s_acc_valid); end
    checks++; if (s_acc !== 17'd131071) begin fails++; $display("FAIL sat_result got %0d want 131071", s_acc); end
    checks++; if (s_ovf !== 1'b1) begin fails++; $display("FAIL sat_result_ovf got %0d want 1", s_ovf); end
    tick();
    checks++; if (s_ovf !== 1'b0) begin fails++; $display("FAIL sat_ovf_clear got %0d want 0", s_ovf); end
    s_prod = 16'd1; s_prod_valid = 1'b1; tick(); s_prod_valid = 1'b0;
    checks++; if (s_acc !== 17'd1) begin fails++; $display("FAIL sat_next_sum got %0d want 1", s_acc); end
    checks++; if (s_ovf !== 1'b0) begin fails++; $display("FAIL sat_next_ovf got %0d want 0", s_ovf); end
  endtask

  task automatic test_backpressure();
    acc_ready = 1'b0;
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    prod = 16'd7; prod_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (acc !== 24'd10) begin fails++; $display("FAIL bp_acc_stable cycle %0d got %0d want 10", i, acc); end
      checks++; if (prod_ready !== 1'b0) begin fails++; $display("FAIL bp_ready cycle %0d got %0d want 0", i, prod_ready); end
      checks++; if (acc_valid !== 1'b1) begin fails++; $display("FAIL bp_valid cycle %0d got %0d want 1", i, acc_valid); end
      checks++; if (cnt !== 3'd4) begin fails++; $display("FAIL bp_cnt cycle %0d got %0d want 4", i, cnt); end
    end
    acc_ready = 1'b1;
    tick();
    checks++; if (acc !== 24'd0) begin fails++; $display("FAIL bp_nothing_consumed got %0d want 0", acc); end
    repeat (4) tick();
    prod_valid = 1'b0;
    checks++; if (acc_valid !== 1'b1) begin fails++; $display("FAIL bp_second_valid got %0d want 1", acc_valid); end
    checks++; if (acc !== 24'd28) begin fails++; $display("FAIL bp_second_acc got %0d want 28", acc); end
    tick();
  endtask

  task automatic test_clear();
    acc_ready = 1'b1;
    send(16'd5); send(16'd7);
    checks++; if (acc !== 24'd12) begin fails++; $display("FAIL clr_pre_acc got %0d want 12", acc); end
    prod = 16'd9; prod_valid = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; prod_valid = 1'b0;
    checks++; if (cnt !== 3'd0) begin fails++; $display("FAIL clr_cnt got %0d want 0", cnt); end
    checks++; if (acc !== 24'd0) begin fails++; $display("FAIL clr_acc got %0d want 0", acc); end
    checks++; if (prod_ready !== 1'b1) begin fails++; $display("FAIL clr_ready got %0d want 1", prod_ready); end
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    checks++; if (acc_valid !== 1'b1) begin fails++; $display("FAIL clr_result_valid got %0d want 1", acc_valid); end
    checks++; if (acc !== 24'd10) begin fails++; $display("FAIL clr_result got %0d want 10", acc); end
    tick();
    acc_ready = 1'b0;
    send(16'd2); send(16'd2); send(16'd2); send(16'd2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (acc_valid !== 1'b0) begin fails++; $display("FAIL clr_hold_drop got %0d want 0", acc_valid); end
    checks++; if (acc !== 24'd0) begin fails++; $display("FAIL clr_hold_acc got %0d want 0", acc); end
  endtask

  task automatic test_async_reset_hold();
    acc_ready = 1'b0;
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    checks++; if (acc_valid !== 1'b1) begin fails++; $display("FAIL ar_pre_valid got %0d want 1", acc_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (acc_valid !== 1'b0) begin fails++; $display("FAIL ar_valid got %0d want 0", acc_valid); end
    checks++; if (acc !== 24'd0) begin fails++; $display("FAIL ar_acc got %0d want 0", acc); end
    checks++; if (cnt !== 3'd0) begin fails++; $display("FAIL ar_cnt got %0d want 0", cnt); end
    checks++; if (ovf !== 1'b0) begin fails++; $display("FAIL ar_ovf got %0d want 0", ovf); end
    checks++; if (prod_ready !== 1'b0) begin fails++; $display("FAIL ar_ready got %0d want 0", prod_ready); end
    tick();
    rst = 1'b0;
    acc_ready = 1'b1;
    tick();
    checks++; if (prod_ready !== 1'b1) begin fails++; $display("FAIL ar_resume_ready got %0d want 1", prod_ready); end
    send(16'd6);
    checks++; if (acc !== 24'd6) begin fails++; $display("FAIL ar_resume_acc got %0d want 6", acc); end
    checks++; if (cnt !== 3'd1) begin fails++; $display("FAIL ar_resume_cnt got %0d want 1", cnt); end
  endtask

  initial begin
    rst = 1'b1;
    prod = 16'd0; prod_valid = 1'b0; clear = 1'b0; acc_ready = 1'b0;
    s_prod = 16'd0; s_prod_valid = 1'b0; s_clear = 1'b0; s_acc_ready = 1'b0;
    test_reset();
    test_basic_sum();
    test_saturation();
    test_backpressure();
    test_clear();
    test_async_reset_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
